// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, format encoding and pipeline entry type.
// Imported by the decode stage and its immediate generator.
package riscv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Opcode includes instr[1:0], so compressed encodings fall to FMT_ILL.
    function automatic fmt_e decode_fmt(input logic [6:0] opcode);
        fmt_e f;
        f = FMT_ILL;
        unique case (opcode)
            OP_REG:    f = FMT_R;
            OP_IMM:    f = FMT_I;
            OP_LOAD:   f = FMT_I;
            OP_JALR:   f = FMT_I;
            OP_SYSTEM: f = FMT_I;
            OP_FENCE:  f = FMT_I;
            OP_STORE:  f = FMT_S;
            OP_BRANCH: f = FMT_B;
            OP_LUI:    f = FMT_U;
            OP_AUIPC:  f = FMT_U;
            OP_JAL:    f = FMT_J;
            default:   f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: sign-extended immediate from instruction bits
// and the already-decoded format.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: two-entry main/skid buffer feeding an RV32I field decoder.
// in_ready depends only on registered skid state, never on out_ready.
module instr_decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [31:0] out_imm,
    output logic [2:0]  out_fmt,
    output logic        out_illegal
);

    entry_t      main_q;
    entry_t      skid_q;
    logic        accept;
    logic        drain;
    logic        main_free;
    fmt_e        fmt;
    logic [31:0] imm;

    assign in_ready  = ~skid_q.valid & ~reset;
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = main_q.valid & out_ready;
    assign main_free = ~main_q.valid | drain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
        end else if (main_free) begin
            if (skid_q.valid) begin
                main_q       <= skid_q;
                skid_q.valid <= accept;
                if (accept) begin
                    skid_q.instr <= in_instr;
                    skid_q.pc    <= in_pc;
                end
            end else begin
                main_q.valid <= accept;
                if (accept) begin
                    main_q.instr <= in_instr;
                    main_q.pc    <= in_pc;
                end
            end
        end else if (accept) begin
            // Main is stalled, so the new word parks in skid.
            skid_q.valid <= 1'b1;
            skid_q.instr <= in_instr;
            skid_q.pc    <= in_pc;
        end
    end

    assign fmt = decode_fmt(main_q.instr[6:0]);

    imm_gen u_imm_gen (
        .instr (main_q.instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        out_valid   = main_q.valid;
        out_pc      = '0;
        out_opcode  = '0;
        out_rd      = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_funct3  = '0;
        out_funct7  = '0;
        out_imm     = '0;
        out_fmt     = '0;
        out_illegal = 1'b0;
        if (main_q.valid) begin
            out_pc      = main_q.pc;
            out_opcode  = main_q.instr[6:0];
            out_rd      = main_q.instr[11:7];
            out_rs1     = main_q.instr[19:15];
            out_rs2     = main_q.instr[24:20];
            out_funct3  = main_q.instr[14:12];
            out_funct7  = main_q.instr[31:25];
            out_imm     = imm;
            out_fmt     = fmt;
            out_illegal = (fmt == FMT_ILL);
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed cases plus random
// traffic checked against a two-deep queue model and a field-level decoder.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    instr_decode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'h1 << (n - 1);
        return (v ^ m) - m;
    endfunction

    function automatic int ref_fmt(input logic [31:0] i);
        case (i[6:0])
            7'h33: return 0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 1;
            7'h23: return 2;
            7'h63: return 3;
            7'h37, 7'h17: return 4;
            7'h6F: return 5;
            default: return 7;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (ref_fmt(i))
            1: return sext(i >> 20, 12);
            2: return sext({20'b0, i[31:25], i[11:7]}, 12);
            3: return sext({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            4: return i & 32'hFFFF_F000;
            5: return sext({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_out(input string tag);
        logic [31:0] i;
        logic [31:0] p;
        bit          v;
        int          f;
        v = (q.size() > 0);
        i = v ? q[0].instr : 32'h0;
        p = v ? q[0].pc : 32'h0;
        f = ref_fmt(i);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'((q.size() < 2) && !reset));
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".pc"}, out_pc, p);
        chk({tag, ".opcode"}, 32'(out_opcode), v ? 32'(i[6:0]) : 0);
        chk({tag, ".rd"}, 32'(out_rd), v ? 32'(i[11:7]) : 0);
        chk({tag, ".rs1"}, 32'(out_rs1), v ? 32'(i[19:15]) : 0);
        chk({tag, ".rs2"}, 32'(out_rs2), v ? 32'(i[24:20]) : 0);
        chk({tag, ".f3"}, 32'(out_funct3), v ? 32'(i[14:12]) : 0);
        chk({tag, ".f7"}, 32'(out_funct7), v ? 32'(i[31:25]) : 0);
        chk({tag, ".imm"}, out_imm, v ? ref_imm(i) : 0);
        chk({tag, ".fmt"}, 32'(out_fmt), v ? 32'(f) : 0);
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(v && f == 7));
    endtask

    // One clock: drive at negedge, update the model at posedge, check at
    // the following negedge.
    task automatic cyc(input string tag, input bit v, input logic [31:0] i,
                       input logic [31:0] p, input bit o, input bit f,
                       output bit acc);
        bit drain;
        in_valid  = v;
        in_instr  = i;
        in_pc     = p;
        out_ready = o;
        flush     = f;
        acc   = v && (q.size() < 2) && !f;
        drain = (q.size() > 0) && o;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (drain) void'(q.pop_front());
            if (acc) q.push_back('{instr: i, pc: p});
        end
        @(negedge clk);
        check_out(tag);
    endtask

    logic [6:0] opcs [14] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                              7'h00, 7'h7F, 7'h31};

    initial begin
        bit          a;
        logic [31:0] r;
        logic [31:0] ins;
        int          n;

        reset = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0;
        out_ready = 0; flush = 0;
        @(negedge clk);
        check_out("reset");
        reset = 1'b0;
        #1 chk("post_reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        cyc("addi", 1, 32'h0050_0093, 32'h0, 0, 0, a);
        chk("addi.valid", 32'(out_valid), 1);
        chk("addi.opcode", 32'(out_opcode), 32'h13);
        chk("addi.rd", 32'(out_rd), 1);
        chk("addi.rs1", 32'(out_rs1), 0);
        chk("addi.imm", out_imm, 5);
        chk("addi.fmt", 32'(out_fmt), 1);

        cyc("sw", 1, 32'h0020_A423, 32'h10, 1, 0, a);
        chk("sw.imm", out_imm, 8);
        chk("sw.rs1", 32'(out_rs1), 1);
        chk("sw.rs2", 32'(out_rs2), 2);
        cyc("beq", 1, 32'hFE00_0EE3, 32'h14, 1, 0, a);
        chk("beq.imm", out_imm, 32'hFFFF_FFFC);
        cyc("lui", 1, 32'h1234_52B7, 32'h18, 1, 0, a);
        chk("lui.rd", 32'(out_rd), 5);
        chk("lui.imm", out_imm, 32'h1234_5000);
        cyc("ones", 1, 32'hFFFF_FFFF, 32'h1C, 1, 0, a);
        chk("ones.illegal", 32'(out_illegal), 1);
        chk("ones.fmt", 32'(out_fmt), 7);
        chk("ones.imm", out_imm, 0);
        cyc("nop", 1, 32'h0000_0013, 32'h20, 1, 0, a);
        chk("nop.illegal", 32'(out_illegal), 0);
        chk("nop.fmt", 32'(out_fmt), 1);
        cyc("idle", 0, 0, 0, 1, 0, a);

        // Stall: pc 0 in main, pc 4 in skid, pc 8 held off.
        cyc("stall0", 1, 32'h0000_0013, 32'h0, 0, 0, a);
        cyc("stall1", 1, 32'h0000_0013, 32'h4, 0, 0, a);
        chk("stall1.in_ready", 32'(in_ready), 0);
        cyc("stall2", 1, 32'h0000_0013, 32'h8, 0, 0, a);
        chk("stall2.pc", out_pc, 32'h0);
        chk("stall2.acc", 32'(a), 0);
        n = 0;
        a = 0;
        while (!a && n < 4) begin
            cyc("release", 1, 32'h0000_0013, 32'h8, 1, 0, a);
            n++;
        end
        chk("release.accepted", 32'(a), 1);
        chk("release.pc8", out_pc, 32'h8);
        cyc("release.tail", 0, 0, 0, 1, 0, a);
        chk("release.empty", 32'(out_valid), 0);

        // Flush with both entries full and input presented.
        cyc("fill0", 1, 32'h0000_0013, 32'h100, 0, 0, a);
        cyc("fill1", 1, 32'h0000_0013, 32'h104, 0, 0, a);
        cyc("flush", 1, 32'h0000_0013, 32'h108, 0, 1, a);
        chk("flush.valid", 32'(out_valid), 0);
        chk("flush.in_ready", 32'(in_ready), 1);
        cyc("post_flush", 0, 0, 0, 1, 0, a);
        chk("post_flush.valid", 32'(out_valid), 0);

        for (int k = 0; k < 400; k++) begin
            r = $urandom();
            ins = (r[3:0] == 4'hF) ? 32'hFFFF_FFFF
                                   : {r[31:7], opcs[$urandom_range(0, 13)]};
            cyc("rand", ($urandom_range(0, 3) != 0), ins, 32'($urandom()),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), a);
        end

        // Reset mid-operation with skid full.
        n = 0;
        while (q.size() < 2 && n < 8) begin
            cyc("prefill", 1, 32'h0020_A423, 32'h200 + 32'(n), 0, 0, a);
            n++;
        end
        chk("prefill.in_ready", 32'(in_ready), 0);
        reset = 1'b1;
        q.delete();
        #1 check_out("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        #1 chk("mid_reset.release.in_ready", 32'(in_ready), 1);
        chk("mid_reset.release.valid", 32'(out_valid), 0);
        @(negedge clk);
        cyc("after_reset", 1, 32'h0050_0093, 32'h300, 1, 0, a);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  fetch presents in_instr/in_pc this cycle.
REQ-004 SHALL have port: in_instr  input  32  raw fetched instruction word.
REQ-005 SHALL have port: in_pc  input  32  PC of in_instr.
REQ-006 SHALL have port: in_ready  output  1  stage accepts input this cycle.
REQ-007 SHALL have port: flush  input  1  discard all held instructions (branch/jump redirect).
REQ-008 SHALL have port: out_valid  output  1  decoded instruction available.
REQ-009 SHALL have port: out_ready  input  1  downstream consumes the instruction this cycle.
REQ-010 SHALL have port: out_pc  output  32  PC of the decoded instruction.
REQ-011 SHALL have ports: out_opcode 7, out_rd 5, out_rs1 5, out_rs2 5, out_funct3 3, out_funct7 7 (all outputs), each the raw RV32I bit field.
REQ-012 SHALL have port: out_imm  output  32  sign-extended immediate.
REQ-013 SHALL have port: out_fmt  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-014 SHALL have port: out_illegal  output  1  unsupported opcode or instr[1:0] != 2'b11.

Function
REQ-015 SHALL transfer input on a cycle with in_valid=1 and in_ready=1, and output on a cycle with out_valid=1 and out_ready=1.
REQ-016 SHALL hold two entries, main and skid, each storing instr, pc and a valid bit; outputs are decoded from main.
REQ-017 SHALL present an accepted instruction with out_valid=1 on the cycle after acceptance when main is empty or drains in that cycle (1-cycle latency).
REQ-018 SHALL drive in_ready = NOT skid.valid, from a register with no combinational path from out_ready.
REQ-019 SHALL, when input is accepted while main is valid and not draining, store it in skid.
REQ-020 SHALL, when main drains while skid is valid, move skid to main and capture any accepted input into skid; no instruction may be lost, duplicated or reordered.
REQ-021 SHALL keep all out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on flush=1, clear main.valid and skid.valid at the next edge, drop any input presented in the same cycle, and drive in_ready=1 on the next cycle.
REQ-023 SHALL decode opcodes: 0110011 R; 0010011, 0000011, 1100111, 1110011, 0001111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; any other opcode gives fmt 7 and out_illegal=1.
REQ-024 SHALL form imm per RV32I: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]}; B {19{i31},i31,i7,i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {11{i31},i31,i[19:12],i20,i[30:21],0}; R and illegal give 0.
REQ-025 SHALL drive out_rd/rs1/rs2/funct3/funct7 as raw fields regardless of format.
REQ-026 SHALL drive all out_* except out_valid to 0 when main.valid=0.

Reset
REQ-027 SHALL clear main.valid, skid.valid and the stored instr/pc asynchronously while reset=1, giving out_valid=0 and all out_* = 0.
REQ-028 SHALL drive in_ready=0 while reset=1 and in_ready=1 on the first cycle after deassertion.
REQ-029 SHALL discard in-flight instructions when reset is asserted mid-operation.

Structure
REQ-030 SHALL take opcode constants and the fmt encoding from shared package riscv_pkg.
REQ-031 SHALL implement immediate generation as sub-module imm_gen (instr and fmt in, imm out).

Verification
REQ-032 SHALL check 0x00500093 @pc 0x0 -> next cycle out_valid=1, opcode 0x13, rd 1, rs1 0, imm 5, fmt 1.
REQ-033 SHALL check 0x0020A423, 0xFE000EE3, 0x123452B7 -> S imm 8, rs1 1, rs2 2; B imm 0xFFFFFFFC; U rd 5, imm 0x12345000.
REQ-034 SHALL check out_ready=0 for 3 cycles with back-to-back inputs pc 0,4,8 -> in_ready falls after pc 4 enters skid, outputs hold pc 0; on release the stage emits 0,4,8 in order with no gaps.
REQ-035 SHALL check flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed PCs never appear.
REQ-036 SHALL check 0xFFFFFFFF and 0x00000013 -> out_illegal=0 and fmt 1 for 0x13; 0xFFFFFFFF gives illegal=1, fmt 7, imm 0.
REQ-037 SHALL check reset asserted with skid full -> same cycle out_valid=0 and all out_* = 0; after release in_ready=1.
